// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants used by the ALU and its sequencers,
// the multiply sequencer state encoding and the default datapath width.
package alu_pkg;

   localparam int DEFAULT_WIDTH = 64;
   localparam int DEFAULT_CNT_W = 7;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_ORR = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_CPZ = 4'b0111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } seq_state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Bus between the execute stage (master) and the multiply sequencer (slave),
// including the sequencer's borrowed view of the shared ALU.
interface alu_mul_seq_if
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             start;
   logic             flush;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product;
   logic             alu_req;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] alu_result;

   modport master (
      output start, flush, op_a, op_b, alu_result,
      input  busy, done, product, alu_req, alu_a, alu_b, alu_op
   );

   modport slave (
      input  start, flush, op_a, op_b, alu_result,
      output busy, done, product, alu_req, alu_a, alu_b, alu_op
   );
endinterface

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add multiply sequencer that borrows the shared ALU for its adds.
// Optional early termination when the remaining multiplier is zero: ALU_MUL_EARLY_TERM_EN.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input logic         clk,
   input logic         rst_n,
   alu_mul_seq_if.slave bus
);

`ifdef ALU_MUL_EARLY_TERM_EN
   localparam bit EARLY_TERM = 1'b1;
`else
   localparam bit EARLY_TERM = 1'b0;
`endif

   localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

   seq_state_e       state_r;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0] mplier_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] product_r;
   logic [WIDTH-1:0] alu_a_r;
   logic [WIDTH-1:0] alu_b_r;
   logic [3:0]       alu_op_r;
   logic             busy_r;
   logic             done_r;
   logic             alu_req_r;

   logic [WIDTH-1:0] mcand_nx_s;
   logic [WIDTH-1:0] mplier_nx_s;
   logic             last_s;
   logic             skip_s;
   logic             first_req_s;

   // Next shift values and iteration-end decisions for the current RUN cycle
   always_comb begin
      mcand_nx_s  = mcand_r << 1;
      mplier_nx_s = mplier_r >> 1;
      last_s      = (cnt_r == CNT_TOP) || (EARLY_TERM && (mplier_nx_s == ZERO));
      skip_s      = EARLY_TERM && (mplier_r == ZERO);
      if (EARLY_TERM) begin
         first_req_s = (bus.op_b != ZERO);
      end else begin
         first_req_s = 1'b1;
      end
   end

   // Sequencer FSM; ALU operand outputs are registered shadows of the values acc/mcand/mplier take
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         acc_r     <= ZERO;
         mcand_r   <= ZERO;
         mplier_r  <= ZERO;
         cnt_r     <= {CNT_W{1'b0}};
         product_r <= ZERO;
         alu_a_r   <= ZERO;
         alu_b_r   <= ZERO;
         alu_op_r  <= OP_AND;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         alu_req_r <= 1'b0;
      end else if (bus.flush) begin
         state_r   <= ST_IDLE;
         alu_a_r   <= ZERO;
         alu_b_r   <= ZERO;
         alu_op_r  <= OP_AND;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         alu_req_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  state_r   <= ST_RUN;
                  acc_r     <= ZERO;
                  mcand_r   <= bus.op_a;
                  mplier_r  <= bus.op_b;
                  cnt_r     <= {CNT_W{1'b0}};
                  busy_r    <= 1'b1;
                  alu_req_r <= first_req_s;
                  alu_op_r  <= first_req_s ? OP_ADD : OP_AND;
                  alu_a_r   <= ZERO;
                  alu_b_r   <= (first_req_s && bus.op_b[0]) ? bus.op_a : ZERO;
               end else begin
                  busy_r    <= 1'b0;
                  alu_req_r <= 1'b0;
               end
            end
            ST_RUN: begin
               if (skip_s) begin
                  state_r   <= ST_DONE;
                  done_r    <= 1'b1;
                  product_r <= acc_r;
               end else begin
                  acc_r    <= bus.alu_result;
                  mcand_r  <= mcand_nx_s;
                  mplier_r <= mplier_nx_s;
                  cnt_r    <= cnt_r + CNT_W'(1);
                  if (last_s) begin
                     state_r   <= ST_DONE;
                     done_r    <= 1'b1;
                     product_r <= bus.alu_result;
                     alu_req_r <= 1'b0;
                     alu_op_r  <= OP_AND;
                     alu_a_r   <= ZERO;
                     alu_b_r   <= ZERO;
                  end else begin
                     alu_a_r <= bus.alu_result;
                     alu_b_r <= mplier_r[1] ? mcand_nx_s : ZERO;
                  end
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r   <= ST_IDLE;
               alu_a_r   <= ZERO;
               alu_b_r   <= ZERO;
               alu_op_r  <= OP_AND;
               busy_r    <= 1'b0;
               done_r    <= 1'b0;
               alu_req_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.product = product_r;
   assign bus.alu_req = alu_req_r;
   assign bus.alu_a   = alu_a_r;
   assign bus.alu_b   = alu_b_r;
   assign bus.alu_op  = alu_op_r;

endmodule
